// File: rtl/div_sequencer_pkg.sv
// Shared encodings for the iterative RV32M divide sequencer: funct3 codes,
// instruction fields that qualify a divide, and FSM state encodings.
package div_sequencer_pkg;

    localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic is_signed_op(input logic [2:0] f3);
        return (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    endfunction

    function automatic logic is_rem_op(input logic [2:0] f3);
        return (f3 == FUNCT3_REM) || (f3 == FUNCT3_REMU);
    endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-divide iteration: shift {rem,quo} left, trial-subtract divisor.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module div_restoring_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] rem_shift;
    logic [XLEN:0] trial;

    // The shifted remainder can reach 2*divisor-1, so the trial needs XLEN+1 bits.
    assign rem_shift = {rem, quo[XLEN-1]};
    assign trial     = rem_shift - {1'b0, divisor};

    always_comb begin
        rem_next = rem_shift[XLEN-1:0];
        quo_next = {quo[XLEN-2:0], 1'b0};
        if (!trial[XLEN]) begin
            rem_next    = trial[XLEN-1:0];
            quo_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// EX-stage DIV/DIVU/REM/REMU sequencer, 32-iteration restoring divide.
// Latency: 34 cycles in EX (33 stall), 2 cycles (1 stall) for div-by-zero/overflow.
// Backpressure: stall holds the upstream pipeline; result is taken on the result_valid pulse.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t       state;
    logic [CNT_W-1:0] counter;
    logic [2:0]       funct3_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  divisor_q;
    logic             quo_neg_q;
    logic             rem_neg_q;

    logic            op_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_by_zero;
    logic            overflow;
    logic [XLEN-1:0] special_result;

    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] fixed_quo;
    logic [XLEN-1:0] fixed_rem;
    logic [XLEN-1:0] final_result;

    assign op_signed = is_signed_op(funct3);
    assign a_neg     = op_signed && op_a[XLEN-1];
    assign b_neg     = op_signed && op_b[XLEN-1];
    assign abs_a     = a_neg ? (~op_a + 1'b1) : op_a;
    assign abs_b     = b_neg ? (~op_b + 1'b1) : op_b;

    assign div_by_zero = (op_b == '0);
    assign overflow    = op_signed && (op_a == INT_MIN) && (op_b == '1);

    // Overflow quotient is INT_MIN, which is op_a itself in that case.
    always_comb begin
        special_result = '0;
        if (div_by_zero) begin
            special_result = is_rem_op(funct3) ? op_a : '1;
        end else if (!is_rem_op(funct3)) begin
            special_result = op_a;
        end
    end

    div_restoring_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    assign fixed_quo    = quo_neg_q ? (~step_quo + 1'b1) : step_quo;
    assign fixed_rem    = rem_neg_q ? (~step_rem + 1'b1) : step_rem;
    assign final_result = is_rem_op(funct3_q) ? fixed_rem : fixed_quo;

    assign stall = ((state == DIV_IDLE) && start && !kill) || (state == DIV_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= DIV_IDLE;
            counter      <= '0;
            funct3_q     <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            divisor_q    <= '0;
            quo_neg_q    <= 1'b0;
            rem_neg_q    <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else if (kill) begin
            state        <= DIV_IDLE;
            result_valid <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    result_valid <= 1'b0;
                    if (start) begin
                        funct3_q  <= funct3;
                        divisor_q <= abs_b;
                        quo_neg_q <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        if (div_by_zero || overflow) begin
                            result       <= special_result;
                            result_valid <= 1'b1;
                            state        <= DIV_DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= abs_a;
                            counter <= '0;
                            state   <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    rem_q   <= step_rem;
                    quo_q   <= step_quo;
                    counter <= counter + 1'b1;
                    if (counter == LAST_ITER) begin
                        result       <= final_result;
                        result_valid <= 1'b1;
                        state        <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    // The finished instruction is still in EX; start must not re-trigger here.
                    result_valid <= 1'b0;
                    state        <= DIV_IDLE;
                end
                default: begin
                    result_valid <= 1'b0;
                    state        <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: table of divide vectors plus kill,
// back-to-back and mid-operation reset sequences.
module tb_div_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        kill;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;

    int n_checks = 0;
    int n_fail   = 0;

    div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .funct3       (funct3),
        .op_a         (op_a),
        .op_b         (op_b),
        .kill         (kill),
        .stall        (stall),
        .result       (result),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_stalls;
        int          exp_vcyc;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Holds start until the result_valid cycle; cycle 1 is the accept cycle.
    task automatic run_op(input logic sync, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, output int stalls, output int vcyc,
                          output logic [31:0] res);
        stalls = 0;
        vcyc   = 0;
        res    = '0;
        if (sync) @(negedge clk);
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        for (int c = 1; c <= 60 && vcyc == 0; c++) begin
            #1;
            if (stall) stalls++;
            if (result_valid) begin
                vcyc = c;
                res  = result;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_op(input string name, input int stalls, input int vcyc,
                            input logic [31:0] res, input int exp_stalls, input int exp_vcyc,
                            input logic [31:0] exp_res);
        check({name, " stalls"}, 32'(stalls), 32'(exp_stalls));
        check({name, " valid_cycle"}, 32'(vcyc), 32'(exp_vcyc));
        check({name, " result"}, res, exp_res);
    endtask

    initial begin
        int          st;
        int          vc;
        int          pulses;
        logic [31:0] r;

        vecs[0]  = '{"divu_100_7",    3'b101, 32'd100,        32'd7,          32'd14,         33, 34};
        vecs[1]  = '{"remu_100_7",    3'b111, 32'd100,        32'd7,          32'd2,          33, 34};
        vecs[2]  = '{"div_m7_2",      3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 34};
        vecs[3]  = '{"rem_m7_2",      3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 34};
        vecs[4]  = '{"rem_7_m2",      3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          33, 34};
        vecs[5]  = '{"div_5_0",       3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  2};
        vecs[6]  = '{"remu_5_0",      3'b111, 32'd5,          32'd0,          32'd5,          1,  2};
        vecs[7]  = '{"div_ovf",       3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  2};
        vecs[8]  = '{"rem_ovf",       3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  2};
        vecs[9]  = '{"divu_intmin_m1",3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33, 34};
        vecs[10] = '{"divu_max_1",    3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33, 34};
        vecs[11] = '{"divu_max_big",  3'b101, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          33, 34};
        vecs[12] = '{"remu_max_big",  3'b111, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  33, 34};
        vecs[13] = '{"div_m100_m7",   3'b100, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         33, 34};
        vecs[14] = '{"rem_m100_m7",   3'b110, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  33, 34};

        rst    = 1'b1;
        start  = 1'b0;
        kill   = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset stall", 32'(stall), 32'd0);
        check("reset result_valid", 32'(result_valid), 32'd0);
        check("reset result", result, 32'd0);

        for (int i = 0; i < 15; i++) begin
            run_op(1'b1, vecs[i].f3, vecs[i].a, vecs[i].b, st, vc, r);
            check_op(vecs[i].name, st, vc, r, vecs[i].exp_stalls, vecs[i].exp_vcyc, vecs[i].exp_res);
        end

        // kill with start in IDLE: no stall that cycle, and nothing starts
        @(negedge clk);
        start  = 1'b1;
        kill   = 1'b1;
        funct3 = 3'b101;
        op_a   = 32'd100;
        op_b   = 32'd7;
        #1;
        check("kill_idle stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b0;
        #1;
        check("kill_idle no_busy", 32'(stall), 32'd0);

        // kill during BUSY at iteration 10 (overall cycle 12)
        @(negedge clk);
        start = 1'b1;
        repeat (11) @(negedge clk);
        kill = 1'b1;
        #1;
        check("kill_busy stall", 32'(stall), 32'd1);
        @(negedge clk);
        kill  = 1'b0;
        start = 1'b0;
        #1;
        check("kill_busy next stall", 32'(stall), 32'd0);
        check("kill_busy next valid", 32'(result_valid), 32'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (result_valid) pulses++;
        end
        check("kill_busy pulses", 32'(pulses), 32'd0);
        run_op(1'b1, 3'b101, 32'd9, 32'd3, st, vc, r);
        check_op("after_kill divu_9_3", st, vc, r, 33, 34, 32'd3);

        // back-to-back: second start in the cycle right after DONE
        run_op(1'b1, 3'b101, 32'd1000, 32'd10, st, vc, r);
        check_op("b2b first", st, vc, r, 33, 34, 32'd100);
        run_op(1'b0, 3'b101, 32'd77, 32'd11, st, vc, r);
        check_op("b2b second", st, vc, r, 33, 34, 32'd7);
        #1;
        check("b2b no_extra_valid", 32'(result_valid), 32'd0);
        check("b2b idle stall", 32'(stall), 32'd0);

        // synchronous reset mid-BUSY clears state and result
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'b101;
        op_a   = 32'd50;
        op_b   = 32'd3;
        repeat (6) @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy stall", 32'(stall), 32'd0);
        check("rst_busy valid", 32'(result_valid), 32'd0);
        check("rst_busy result", result, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Iterative controller and datapath for RV32M DIV/DIVU/REM/REMU in the EX stage. It accepts a divide op from the ID/EX register and runs a 32-iteration restoring divide. While the divide runs, it raises a stall that the pipeline ORs into pc_en, if_id_pipeline_en and the ID/EX hold logic, so the divide stays in EX until its result is ready. MUL ops stay single-cycle in the existing ALU and never reach this block.

Parameters:
XLEN, 32, operand and result width.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  EX holds a valid M-extension divide op (opcode R-type, funct7=0000001, funct3[2]=1).
funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_a  input  XLEN  dividend (rs1 after forwarding).
op_b  input  XLEN  divisor (rs2 after forwarding).
kill  input  1  abort in-flight divide (pipeline flush or trap).
stall  output  1  hold PC, IF/ID and ID/EX; insert a bubble into EX/MEM.
result  output  XLEN  quotient or remainder.
result_valid  output  1  one-cycle pulse; EX/MEM captures result this cycle.

Behaviour:
- States: IDLE, BUSY, DONE. Reset puts the block in IDLE with counter=0, result=0, result_valid=0, and stall=0.
- stall is combinational: (IDLE && start && !kill) || BUSY. It is 0 in DONE, so the pipeline advances on the DONE cycle.
- IDLE + start: latch funct3, |op_a|, |op_b|, quotient sign (a31^b31, signed ops only) and remainder sign (a31, signed ops only).
  - If op_b==0, or the op is signed with op_a=0x80000000 and op_b=0xFFFFFFFF, go to DONE with the special result (below).
  - Otherwise load remainder=0, quotient=|op_a|, counter=0, and go to BUSY.
- BUSY step, one iteration per cycle:
  - {rem,quo} shifted left 1; trial = rem - |b| in XLEN+1 bits.
  - If trial is non-negative: rem=trial and quo[0]=1. Otherwise rem is kept and quo[0]=0.
  - counter increments. After the iteration with counter==XLEN-1, go to DONE.
- DONE: result_valid=1. result is the sign-fixed quotient for DIV/DIVU or the sign-fixed remainder for REM/REMU. Next state is IDLE unconditionally.
- start is ignored in DONE. The same instruction is still in EX that cycle, so a re-trigger must not occur.
- Latency:
  - Normal case: accept cycle + 32 BUSY + 1 DONE = 34 cycles in EX, 33 stall cycles.
  - Special case: accept + DONE = 2 cycles, 1 stall cycle.
- Special results:
  - Divide by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = op_a.
  - Signed overflow: DIV = 0x80000000; REM = 0.
- Sign fixup: negate the quotient if the quotient sign is set and the op is signed. Negate the remainder if the remainder sign is set and the op is signed. Unsigned ops use raw magnitudes.
- Back-to-back divides: IDLE with start in the cycle after DONE starts a new op normally.
- kill: priority rst > kill > FSM. kill in any state forces IDLE next cycle with result_valid=0. stall is 0 in the kill cycle when in IDLE or DONE. In BUSY, stall stays 1 for that cycle and the flush logic owns the pipeline.
- result holds its last value outside DONE. Consumers qualify it with result_valid.

Decomposition:
- Shared defines header:
  - funct3 constants FUNCT3_DIV/DIVU/REM/REMU;
  - OPCODE_RTYPE and FUNCT7_MULDIV;
  - state encodings DIV_IDLE=2'd0, DIV_BUSY=2'd1, DIV_DONE=2'd2.
- One sub-module, div_restoring_step: a combinational single iteration taking rem, quo, divisor and producing next rem and next quo. It is reused if the radix is raised later.

Test Plan:
- DIVU 100/7: stall high for exactly 33 cycles; result_valid pulses once in cycle 34 with result=14; REMU 100/7 -> 2.
- DIV -7/2 -> result=0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; both with 1 stall cycle and result_valid in cycle 2.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; 1 stall cycle.
- kill asserted in BUSY at iteration 10: IDLE next cycle, no result_valid pulse; a following DIVU 9/3 returns 3 with full latency.
- Two back-to-back DIVU ops (start held through DONE, then a new start): exactly two result_valid pulses with correct results; rst asserted mid-BUSY gives IDLE, stall=0 and result=0 on the next cycle.
